// File: rtl/bios_stream_loader_if.sv
// ioctl download port and BIOS word port of the stream loader, bundled.
// master = downloader/consumer side, slave = bios_stream_loader.
interface bios_stream_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        bios_req;
    logic        bios_wr;
    logic [13:0] bios_addr;
    logic [15:0] bios_din;
    logic        bios_loaded;
    logic        overrun;
    logic        too_big;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        input  bios_wr, bios_addr, bios_din, bios_loaded, overrun, too_big
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        output bios_wr, bios_addr, bios_din, bios_loaded, overrun, too_big
    );
endinterface

// File: rtl/bios_stream_loader.sv
// Packs ioctl bytes into 16-bit words staged in two ping-pong banks and
// hands them to the BIOS consumer one word per bios_req strobe.
module bios_stream_loader #(
    parameter int          BANK_WORDS = 64,
    parameter int          MAX_WORDS  = 16384,
    parameter logic [15:0] PAD_WORD   = 16'hFFFF
) (
    input logic                 clk_sys,
    input logic                 reset_n,
    bios_stream_loader_if.slave bus
);
    localparam int             IW         = $clog2(BANK_WORDS);
    localparam logic [IW-1:0]  LAST       = IW'(BANK_WORDS - 1);
    localparam logic [24:0]    BYTE_LIMIT = 25'(2 * MAX_WORDS);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;
    state_t state, state_nx;

    logic [15:0]   mem [2*BANK_WORDS];
    logic [1:0]    full, full_clr, full_eff, full_set;
    logic          dl_q, wrote_any, any_deliv;
    logic [7:0]    lo_byte;
    logic [IW-1:0] last_idx, fl_idx, rd_idx, wr_idx;
    logic          last_bank, fl_bank, rd_bank, wr_bank;
    logic [13:0]   dcnt;
    logic          wr_en, wr_ok, wr_drop;
    logic [15:0]   wr_data;
    logic          dl_start, dl_end, byte_ok, in_range, rd_take, rd_wrap;

    assign dl_start = bus.ioctl_download & ~dl_q;
    assign dl_end   = ~bus.ioctl_download & dl_q;
    assign byte_ok  = bus.ioctl_wr & bus.ioctl_download & ~dl_start & (state == ST_RUN);
    assign in_range = bus.ioctl_addr < BYTE_LIMIT;

    assign rd_take  = bus.bios_req & bus.bios_wr & full[rd_bank];
    assign rd_wrap  = rd_take & (rd_idx == LAST);
    assign full_clr = rd_wrap ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    // The consumer's clear lands before a same-cycle write is judged.
    assign full_eff = full & ~full_clr;
    assign wr_ok    = wr_en & ~full_eff[wr_bank];
    assign wr_drop  = wr_en & full_eff[wr_bank];
    assign full_set = (wr_ok && wr_idx == LAST) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_bank  = 1'b0;
        wr_idx   = '0;
        wr_data  = PAD_WORD;
        if (state == ST_FLUSH) begin
            wr_en   = ~dl_start;
            wr_bank = fl_bank;
            wr_idx  = fl_idx;
            if (fl_idx == LAST) state_nx = ST_RUN;
        end else begin
            if (dl_end && wrote_any && last_idx != LAST) state_nx = ST_FLUSH;
            if (byte_ok && in_range && bus.ioctl_addr[0]) begin
                wr_en   = 1'b1;
                wr_bank = bus.ioctl_addr[IW+1];
                wr_idx  = bus.ioctl_addr[IW:1];
                wr_data = {bus.ioctl_dout, lo_byte};
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_ok && reset_n) mem[{wr_bank, wr_idx}] <= wr_data;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || dl_start) begin
            dl_q            <= reset_n ? bus.ioctl_download : 1'b0;
            state           <= ST_RUN;
            full            <= 2'b00;
            wrote_any       <= 1'b0;
            any_deliv       <= 1'b0;
            lo_byte         <= 8'h00;
            last_idx        <= '0;
            last_bank       <= 1'b0;
            fl_idx          <= '0;
            fl_bank         <= 1'b0;
            rd_idx          <= '0;
            rd_bank         <= 1'b0;
            dcnt            <= 14'd0;
            bus.bios_wr     <= 1'b0;
            bus.bios_addr   <= 14'd0;
            bus.bios_din    <= 16'h0000;
            bus.bios_loaded <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.too_big     <= 1'b0;
        end else begin
            dl_q  <= bus.ioctl_download;
            state <= state_nx;
            full  <= full_eff | full_set;
            if (byte_ok && !in_range) bus.too_big <= 1'b1;
            if (byte_ok && in_range && !bus.ioctl_addr[0]) lo_byte <= bus.ioctl_dout;
            if (byte_ok && in_range && bus.ioctl_addr[0]) begin
                wrote_any <= 1'b1;
                last_idx  <= bus.ioctl_addr[IW:1];
                last_bank <= bus.ioctl_addr[IW+1];
            end
            if (wr_drop) bus.overrun <= 1'b1;
            // Pad from the word after the last one written up to the bank end.
            if (state == ST_RUN && state_nx == ST_FLUSH) begin
                fl_idx  <= last_idx + 1'b1;
                fl_bank <= last_bank;
            end else if (state == ST_FLUSH) begin
                fl_idx <= fl_idx + 1'b1;
            end
            if (rd_take) begin
                bus.bios_din  <= mem[{rd_bank, rd_idx}];
                bus.bios_addr <= dcnt;
                dcnt          <= dcnt + 14'd1;
                any_deliv     <= 1'b1;
                rd_idx        <= rd_idx + 1'b1;
                if (rd_idx == LAST) rd_bank <= ~rd_bank;
            end
            bus.bios_wr <= |full;
            if (!bus.ioctl_download && !dl_q && state == ST_RUN && full == 2'b00 && any_deliv)
                bus.bios_loaded <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bios_stream_loader.sv
// Directed bench for bios_stream_loader: downloads images over ioctl and
// drains them through bios_req, checking every delivered word.
module tb_bios_stream_loader;
    localparam int K_NORM = 0, K_130 = 1, K_SAME = 2;
    localparam int WAIT_LIMIT = 2000;

    logic clk, rst_n;
    int n_chk = 0, n_fail = 0;

    bios_stream_loader_if bus();

    bios_stream_loader dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        return 8'((a % 256) + 37 * (a / 256));
    endfunction

    function automatic logic [15:0] norm(input int k);
        return {pat(2*k + 1), pat(2*k)};
    endfunction

    function automatic logic [15:0] wexp(input int kind, input int k);
        if (kind == K_130) return (k < 65) ? norm(k) : 16'hFFFF;
        if (kind == K_SAME) begin
            if (k == 191) return 16'h3CC3;
            return (k >= 128) ? norm(k - 128) : norm(k);
        end
        return norm(k);
    endfunction

    task automatic write_bytes(input int first, input int count);
        for (int a = first; a < first + count; a++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(a);
            bus.ioctl_dout = pat(a);
            step();
        end
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic consume(input int first, input int n, input int period, input int kind);
        for (int k = first; k < first + n; k++) begin
            int t = 0;
            while (!bus.bios_wr && t < WAIT_LIMIT) begin
                step();
                t++;
            end
            chk("wait_bios_wr", 32'(bus.bios_wr), 32'd1);
            if (!bus.bios_wr) return;
            bus.bios_req = 1'b1;
            step();
            bus.bios_req = 1'b0;
            chk($sformatf("addr_%0d", k), 32'(bus.bios_addr), 32'(k % 16384));
            chk($sformatf("data_%0d", k), 32'(bus.bios_din), 32'(wexp(kind, k)));
            repeat (period - 1) step();
            if (k % 64 == 63) step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"},      32'(bus.bios_wr),     32'd0);
        chk({tag, "_addr"},    32'(bus.bios_addr),   32'd0);
        chk({tag, "_din"},     32'(bus.bios_din),    32'd0);
        chk({tag, "_loaded"},  32'(bus.bios_loaded), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun),     32'd0);
        chk({tag, "_too_big"}, 32'(bus.too_big),     32'd0);
    endtask

    task automatic start_dl();
        bus.ioctl_download = 1'b1;
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr   = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = '0;
        bus.bios_req   = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // zero-length download never reports loaded
        bus.ioctl_download = 1'b1;
        repeat (3) step();
        bus.ioctl_download = 1'b0;
        repeat (5) step();
        chk("zero_len_loaded", 32'(bus.bios_loaded), 32'd0);
        chk("zero_len_wr",     32'(bus.bios_wr),     32'd0);

        // 256 bytes, consumer strobing every 4 cycles
        start_dl();
        fork
            write_bytes(0, 256);
            consume(0, 128, 4, K_NORM);
        join
        bus.ioctl_download = 1'b0;
        repeat (3) step();
        chk("img256_loaded",  32'(bus.bios_loaded), 32'd1);
        chk("img256_overrun", 32'(bus.overrun),     32'd0);
        chk("img256_wr",      32'(bus.bios_wr),     32'd0);

        // 130 bytes: tail of bank 1 padded
        start_dl();
        chk("restart_loaded", 32'(bus.bios_loaded), 32'd0);
        write_bytes(0, 130);
        bus.ioctl_download = 1'b0;
        consume(0, 128, 1, K_130);
        repeat (2) step();
        chk("img130_wr",      32'(bus.bios_wr),     32'd0);
        chk("img130_loaded",  32'(bus.bios_loaded), 32'd1);
        chk("img130_overrun", 32'(bus.overrun),     32'd0);

        // stalled consumer, three banks offered
        start_dl();
        write_bytes(0, 384);
        chk("stall_overrun", 32'(bus.overrun), 32'd1);
        chk("stall_wr",      32'(bus.bios_wr), 32'd1);
        bus.ioctl_download = 1'b0;
        step();
        consume(0, 128, 1, K_NORM);
        repeat (3) step();
        chk("stall_loaded", 32'(bus.bios_loaded), 32'd1);
        chk("stall_wr_end", 32'(bus.bios_wr),     32'd0);

        // last word of bank 0 written in the cycle its full flag is cleared
        start_dl();
        write_bytes(0, 128);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h17E;
        bus.ioctl_dout = 8'hC3;
        step();
        bus.ioctl_wr = 1'b0;
        repeat (2) step();
        consume(0, 63, 1, K_NORM);
        bus.bios_req   = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h17F;
        bus.ioctl_dout = 8'h3C;
        step();
        bus.bios_req = 1'b0;
        bus.ioctl_wr = 1'b0;
        chk("same_addr",    32'(bus.bios_addr), 32'd63);
        chk("same_data",    32'(bus.bios_din),  32'h7F7E);
        chk("same_overrun", 32'(bus.overrun),   32'd0);
        repeat (2) step();
        chk("same_refull", 32'(bus.bios_wr), 32'd1);
        write_bytes(128, 128);
        consume(64, 128, 1, K_SAME);
        bus.ioctl_download = 1'b0;
        repeat (3) step();
        chk("same_overrun_end", 32'(bus.overrun),     32'd0);
        chk("same_loaded",      32'(bus.bios_loaded), 32'd1);

        // reset midway through delivery, then a clean reload
        start_dl();
        fork
            write_bytes(0, 512);
            consume(0, 100, 1, K_NORM);
        join
        rst_n = 1'b0;
        bus.ioctl_download = 1'b0;
        step();
        chk_all_zero("midreset");
        rst_n = 1'b1;
        step();
        start_dl();
        fork
            write_bytes(0, 512);
            consume(0, 256, 1, K_NORM);
        join
        bus.ioctl_download = 1'b0;
        repeat (3) step();
        chk("reload_loaded",  32'(bus.bios_loaded), 32'd1);
        chk("reload_overrun", 32'(bus.overrun),     32'd0);
        chk("reload_addr",    32'(bus.bios_addr),   32'd255);

        // full-size image followed by an out-of-range byte pair
        start_dl();
        fork
            begin
                write_bytes(0, 32768);
                chk("full_too_big_pre", 32'(bus.too_big), 32'd0);
                write_bytes(32'h8000, 2);
            end
            consume(0, 16384, 1, K_NORM);
        join
        chk("big_too_big", 32'(bus.too_big), 32'd1);
        bus.ioctl_download = 1'b0;
        repeat (4) step();
        chk("big_wr",      32'(bus.bios_wr),     32'd0);
        chk("big_loaded",  32'(bus.bios_loaded), 32'd1);
        chk("big_overrun", 32'(bus.overrun),     32'd0);
        chk("big_addr",    32'(bus.bios_addr),   32'h3FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bios_stream_loader.md
Name: bios_stream_loader

Overview:
- Sits between the data_io ioctl download port and the system BIOS write port (BIOS_ADDR/BIOS_DIN/BIOS_WR/BIOS_REQ).
- Packs downloaded bytes little-endian into 16-bit words, and stages them in two 64-word ping-pong banks so the ioctl writer never waits on the consumer.
- Hands words to the consumer one per BIOS_REQ strobe, and raises bios_loaded once the whole image has been drained.

Parameters:
- BANK_WORDS, 64, words per bank; power of two, 2..256.
- MAX_WORDS, 16384, word capacity of the BIOS target; must equal 2^14 to match bios_addr width.
- PAD_WORD, 16'hFFFF, fill value for the unwritten tail of the final partial bank.

Ports:
- clk_sys  in  1  system clock (clk_sdr domain at top level).
- reset_n  in  1  synchronous active-low reset.
- ioctl_download  in  1  high while a download is in progress.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- bios_req  in  1  consumer strobe, one cycle per word taken.
- bios_wr  out  1  high while at least one bank holds undelivered words.
- bios_addr  out  14  word address of the word on bios_din.
- bios_din  out  16  word data.
- bios_loaded  out  1  image fully delivered.
- overrun  out  1  sticky: a word was lost because its bank was still full.
- too_big  out  1  sticky: bytes seen at or above byte address 2*MAX_WORDS.

Behaviour:
- Reset (reset_n low at a clk_sys edge): every output goes to 0; both bank-full flags, the read pointer, the low-byte latch and the download-edge register are cleared.
- Download start (rising ioctl_download, detected through a registered copy): identical clear to reset, except the edge register updates. bios_loaded drops to 0.
- Byte packing:
  - ioctl_wr with ioctl_addr[0]=0 latches the low byte.
  - ioctl_wr with ioctl_addr[0]=1 writes {ioctl_dout, low} to bank ioctl_addr[7], word ioctl_addr[6:1] (for the BANK_WORDS=64 default).
  - Writes are ignored when ioctl_download is low.
- Bytes at ioctl_addr >= 2*MAX_WORDS are dropped and set too_big.
- Bank fill: a write to the last word of bank b sets full[b].
  - If full[b] is already set when any word is to be written into bank b, that word is dropped and overrun is set.
  - The completion of an already-full bank does not re-set full[b].
- Flush:
  - On falling ioctl_download, if the last written word index is not the last word of its bank, the remaining words of that bank are written with PAD_WORD, one per cycle. full[b] is set after the final pad word.
  - During flush the block must not take ioctl input; any ioctl_wr during flush is ignored.
- Delivery:
  - bios_wr = full[0] | full[1], registered.
  - The consumer reads banks in order 0,1,0,1...
  - On bios_req while the current read bank is full: next cycle, bios_din = word[rd_bank][rd_idx] and bios_addr = the global word count delivered so far (starting at 0); rd_idx then increments.
  - Latency from bios_req to updated bios_din/bios_addr is 1 cycle.
  - When rd_idx wraps past the last word, full[rd_bank] clears in that cycle and rd_bank toggles.
  - bios_req while bios_wr is 0 is ignored: no change to pointers or outputs.
- Simultaneous write to bank b and consumer clear of full[b] in the same cycle: the clear takes effect first, and the write is accepted (no overrun).
- bios_addr wraps modulo 2^14. It cannot exceed MAX_WORDS-1 given the too_big filter.
- bios_loaded: set one cycle after all of the following hold: download low, flush done, both full flags clear, at least one word delivered. It holds until reset or the next download start.
- Zero-length download (start and end with no writes): bios_loaded stays 0.
- Reset mid-download or mid-delivery aborts all activity; the partially delivered image is not resumed.

Test Plan:
- 256-byte image, bytes = addr[7:0], consumer strobes bios_req every 4 cycles -> 128 words delivered, bios_addr 0..127, word n = {2n+1, 2n}; bios_loaded=1; overrun=0.
- 130-byte image -> words 0..64 hold the data; words 65..127 = 16'hFFFF; bios_wr falls after word 127; bios_loaded=1.
- Consumer stalled (bios_req=0) while 3 full banks (384 bytes) are downloaded -> banks 0 and 1 retain bytes 0..255; words 128..191 are dropped; overrun=1; words 0..127 delivered intact once bios_req resumes.
- Last word of bank 0 written in the same cycle the consumer clears full[0] -> write accepted; overrun=0; the delivered data matches.
- reset_n low for 1 cycle midway through delivery of a 512-byte image -> all outputs 0; a second full download then delivers 256 words from bios_addr 0 with correct data.
- Byte at ioctl_addr=25'h8000 -> too_big=1; the byte is absent from the output; the preceding 16384 words are delivered normally.
